prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Host-side writer for the instruction memory that the fetch unit reads.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs into 9-bit instructions.
- Writes each instruction to sequential instruction-memory addresses starting at 0.
- After the last write, pulses start to the fetch unit, then holds off new loads until the CPU reports done.

Parameters:
- IW, 9, instruction width; fixed to match the ISA, and the packing rules assume 9.
- AW, 10, instruction memory address width; capacity is 2^AW words.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write enable, one-cycle pulse.
- imem_addr  out  AW  write address.
- imem_wdata  out  IW  write data.
- start  out  1  one-cycle pulse to fetch unit; program begins at address 0.
- cpu_done  in  1  CPU done/halt indication.
- busy  out  1  a load or a program run is in progress.
- error  out  1  sticky framing error.
- words_loaded  out  AW+1  number of instructions written in the current load.

Behaviour:
- Byte accepted on a rising CLK edge when in_valid && in_ready; in_data is ignored otherwise.
- Stream format:
  - Header: count low byte, then count high byte (16-bit count N, little-endian).
  - Then N records of two bytes each: lo = instr[7:0], hi = {7'b0, instr[8]}.
- States:
  - CNT_LO: in_ready=1. Accept -> CNT_HI.
  - CNT_HI: in_ready=1. Accept -> evaluate N:
    - N==0 -> START.
    - N > 2^AW -> ERR.
    - Otherwise -> INS_LO, with the index cleared.
  - INS_LO: in_ready=1, busy=1. Accept -> INS_HI.
  - INS_HI: in_ready=1, busy=1. Accept:
    - in_data[7:1] != 0 -> ERR.
    - Otherwise -> WRITE.
  - WRITE: in_ready=0, busy=1.
    - imem_we=1 for exactly this cycle, with imem_addr=index and imem_wdata={hi[0],lo}.
    - words_loaded increments at the end of the cycle.
    - index == N-1 -> START; else index+1 and -> INS_LO.
  - START: in_ready=0, busy=1, start=1 for exactly this cycle -> RUN.
  - RUN: in_ready=0, busy=1. cpu_done==1 -> CNT_LO, with busy low on the next cycle. words_loaded holds until the next header is accepted.
  - ERR: in_ready=0, busy=0, error=1. Only reset leaves this state.
- busy is 0 in CNT_LO, CNT_HI and ERR.
- Latency:
  - Write occurs in the cycle after the hi byte is accepted.
  - start is asserted in the cycle after the last write.
  - Maximum throughput is one instruction per 3 cycles.
- cpu_done is ignored in every state except RUN; it is sampled in RUN only from the cycle after start.
- Counts and addresses:
  - N is 16-bit unsigned.
  - index runs 0..N-1 and never wraps.
  - N==2^AW is legal and fills memory exactly.
- words_loaded clears to 0 on acceptance of the count low byte.
- Reset (reset==0 at an edge), from any state including mid-record or RUN:
  - State -> CNT_LO; index, N and words_loaded cleared.
  - imem_we, start, busy, error all 0; imem_addr and imem_wdata 0.
  - A half-received record is discarded and no write is issued.
  - in_ready is forced to 0 while reset is low and becomes 1 in the first cycle after reset is released.
- All outputs are registered or decoded from registered state only; there is no combinational path from in_valid to in_ready.

Test Plan:
- Two-word load: bytes 02,00,34,01,FF,00 with in_valid held high ->
  - writes (addr 0, 0x134), then (addr 1, 0x0FF);
  - start pulses one cycle after the second write;
  - words_loaded=2; busy=1 until cpu_done.
- Zero-length program: bytes 00,00 -> no imem_we; start pulses in the cycle after the count high byte is accepted; RUN entered.
- Framing and bounds errors:
  - Header 01,00, then bytes 12,02 -> no write, error=1, in_ready=0; stays in ERR after further in_valid until reset.
  - Header 01,04 (N=1025, AW=10) -> error=1, no write.
- Backpressure and gaps: random in_valid gaps, plus in_valid asserted during WRITE/START/RUN -> those bytes are not consumed, and written data matches the stream exactly.
- Reset mid-record: reset low after the lo byte of word 3 of 5 -> no further writes, outputs 0; a new load afterwards writes from addr 0.
- RUN handshake: cpu_done held 0 for 50 cycles -> in_ready stays 0. cpu_done=1 for one cycle -> next cycle busy=0 and in_ready=1; words_loaded holds until the next header.

Source files
------------

// File: rtl/prog_loader_if.sv
// Host byte stream, instruction-memory write port and CPU run handshake of the program loader.
// The loader is the slave of the host stream; the host/bench side uses the master modport.
interface prog_loader_if #(
  parameter int IW = 9,
  parameter int AW = 10
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          start;
  logic          cpu_done;
  logic          busy;
  logic          error;
  logic [AW:0]   words_loaded;

  modport master (
    output in_valid, in_data, cpu_done,
    input  in_ready, imem_we, imem_addr, imem_wdata, start, busy, error, words_loaded
  );

  modport slave (
    input  in_valid, in_data, cpu_done,
    output in_ready, imem_we, imem_addr, imem_wdata, start, busy, error, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Packs a host byte stream (16-bit count header, then lo/hi byte pairs) into 9-bit
// instructions, writes them from address 0, then pulses start and waits for cpu_done.
module prog_loader #(
  parameter int IW = 9,
  parameter int AW = 10
) (
  input  logic             CLK,
  input  logic             reset,
  prog_loader_if.slave     bus
);

  typedef enum logic [2:0] {
    CNT_LO, CNT_HI, INS_LO, INS_HI, WRITE, START, RUN, ERR
  } state_t;

  localparam int unsigned CAP = 2 ** AW;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] index_q, index_d;
  logic [7:0]    lo_q, lo_d;
  logic          hi_q, hi_d;
  logic [AW:0]   words_q, words_d;
  logic          in_ready_q, in_ready_d;
  logic          accept;
  logic [15:0]   n_new;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= CNT_LO;
      cnt_q      <= '0;
      index_q    <= '0;
      lo_q       <= '0;
      hi_q       <= 1'b0;
      words_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      index_q    <= index_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      words_q    <= words_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    words_d = words_q;
    accept  = bus.in_valid && in_ready_q;
    n_new   = {bus.in_data, cnt_q[7:0]};

    case (state_q)
      CNT_LO: if (accept) begin
        cnt_d[7:0] = bus.in_data;
        words_d    = '0;
        state_d    = CNT_HI;
      end
      CNT_HI: if (accept) begin
        cnt_d[15:8] = bus.in_data;
        if (n_new == 16'd0) begin
          state_d = START;
        end else if (32'(n_new) > CAP) begin
          state_d = ERR;
        end else begin
          index_d = '0;
          state_d = INS_LO;
        end
      end
      INS_LO: if (accept) begin
        lo_d    = bus.in_data;
        state_d = INS_HI;
      end
      INS_HI: if (accept) begin
        if (bus.in_data[7:1] != 7'd0) begin
          state_d = ERR;
        end else begin
          hi_d    = bus.in_data[0];
          state_d = WRITE;
        end
      end
      WRITE: begin
        words_d = words_q + (AW+1)'(1);
        if (16'(index_q) == cnt_q - 16'd1) begin
          state_d = START;
        end else begin
          index_d = index_q + AW'(1);
          state_d = INS_LO;
        end
      end
      START:   state_d = RUN;
      RUN:     if (bus.cpu_done) state_d = CNT_LO;
      ERR:     state_d = ERR;
      default: state_d = CNT_LO;
    endcase

    // Registered ready keeps in_ready low through the reset edge and free of any in_valid path.
    in_ready_d = (state_d == CNT_LO) || (state_d == CNT_HI) ||
                 (state_d == INS_LO) || (state_d == INS_HI);
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.imem_we      = (state_q == WRITE);
  assign bus.imem_addr    = index_q;
  assign bus.imem_wdata   = {hi_q, lo_q};
  assign bus.start        = (state_q == START);
  assign bus.busy         = (state_q == INS_LO) || (state_q == INS_HI) ||
                            (state_q == WRITE)  || (state_q == START)  ||
                            (state_q == RUN);
  assign bus.error        = (state_q == ERR);
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader: a stream-level model queues the expected
// writes and start pulse, and a monitor pops them as the loader presents imem_we/start.
module tb_prog_loader;
  localparam int IW = 9;
  localparam int AW = 10;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic          is_start;
    logic          after_write;
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } ev_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   starts_seen = 0;
  int   last_we = -10;
  ev_t  exp_q[$];

  prog_loader_if #(.IW(IW), .AW(AW)) bus();
  prog_loader #(.IW(IW), .AW(AW)) dut (.CLK(CLK), .reset(reset), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream-level reference: 0 = complete load, 1 = framing/bounds error, 2 = stream cut short.
  function automatic int model(input byte_q_t s, output int n);
    ev_t        e;
    logic [7:0] lo, hi;
    n = 0;
    if (s.size() < 2) return 2;
    n = int'({s[1], s[0]});
    if (n > (1 << AW)) return 1;
    for (int i = 0; i < n; i++) begin
      if (s.size() < 2 * i + 4) return 2;
      lo = s[2 * i + 2];
      hi = s[2 * i + 3];
      if (hi > 8'd1) return 1;
      e.is_start    = 1'b0;
      e.after_write = 1'b0;
      e.addr        = AW'(i);
      e.data        = {hi[0], lo};
      exp_q.push_back(e);
    end
    e.is_start    = 1'b1;
    e.after_write = (n > 0);
    e.addr        = '0;
    e.data        = '0;
    exp_q.push_back(e);
    return 0;
  endfunction

  always @(negedge CLK) begin
    ev_t e;
    cyc++;
    if (reset && (bus.imem_we === 1'b1 || bus.start === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {bus.imem_we, bus.start}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (bus.start === 1'b1) begin
          starts_seen++;
          chk("event_is_start", 32'(e.is_start), 32'd1);
          chk("start_busy", 32'(bus.busy), 32'd1);
          chk("start_we_overlap", 32'(bus.imem_we), 32'd0);
          if (e.after_write) chk("start_after_last_write", 32'(cyc - last_we), 32'd1);
        end else begin
          last_we = cyc;
          chk("event_is_write", 32'(e.is_start), 32'd0);
          chk("write_addr", 32'(bus.imem_addr), 32'(e.addr));
          chk("write_data", 32'(bus.imem_wdata), 32'(e.data));
          chk("write_in_ready", 32'(bus.in_ready), 32'd0);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic took;
    int   g;
    took = 1'b0;
    g    = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!took && g < 200) begin
      took = bus.in_ready;
      bus.cpu_done = 1'($urandom_range(0, 1));
      @(negedge CLK);
      g++;
    end
    bus.in_valid = 1'b0;
    bus.cpu_done = 1'b0;
    bus.in_data  = 8'($urandom);
    if (!took) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.cpu_done = 1'b0;
    bus.in_valid = 1'($urandom_range(0, 1));
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("rst_words", 32'(bus.words_loaded), 32'd0);
    chk("pending_events_at_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge CLK);
    chk("ready_after_release", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_load(input byte_q_t s, input bit gaps, input int hold);
    int   n, st, s0, g;
    logic saw;
    st = model(s, n);
    s0 = starts_seen;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
      send_byte(s[i]);
      if (st == 0 && i == 1 && n == 0) chk("start_after_header", 32'(bus.start), 32'd1);
      if (st != 1 && i >= 3 && (i % 2) == 1) begin
        chk("we_latency", 32'(bus.imem_we), 32'd1);
        chk("we_latency_addr", 32'(bus.imem_addr), 32'((i - 3) / 2));
      end
    end
    if (st == 1) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      repeat (8) @(negedge CLK);
      chk("err_flag", 32'(bus.error), 32'd1);
      chk("err_in_ready", 32'(bus.in_ready), 32'd0);
      chk("err_busy", 32'(bus.busy), 32'd0);
      bus.in_valid = 1'b0;
      do_reset();
    end else if (st == 2) begin
      repeat (2) @(negedge CLK);
      do_reset();
    end else begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      g = 0;
      while (starts_seen == s0 && g < 40) begin
        @(negedge CLK);
        g++;
      end
      chk("start_seen", 32'(starts_seen != s0), 32'd1);
      @(negedge CLK);
      saw = 1'b0;
      repeat (hold) begin
        @(negedge CLK);
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) saw = 1'b1;
      end
      chk("run_ready_low_busy_high", 32'(saw), 32'd0);
      chk("run_in_ready", 32'(bus.in_ready), 32'd0);
      chk("run_words", 32'(bus.words_loaded), 32'(n));
      chk("run_pending_events", 32'(exp_q.size()), 32'd0);
      bus.in_valid = 1'b0;
      bus.cpu_done = 1'b1;
      @(negedge CLK);
      bus.cpu_done = 1'b0;
      chk("done_busy", 32'(bus.busy), 32'd0);
      chk("done_in_ready", 32'(bus.in_ready), 32'd1);
      chk("done_words_hold", 32'(bus.words_loaded), 32'(n));
      @(negedge CLK);
      chk("idle_words_hold", 32'(bus.words_loaded), 32'(n));
    end
  endtask

  task automatic rand_stream(input int n, input bit allow_err, output byte_q_t s);
    int bad;
    s.delete();
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    bad = (allow_err && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
    for (int i = 0; i < n; i++) begin
      s.push_back(8'($urandom));
      if (i == bad) begin
        s.push_back(8'($urandom_range(2, 255)));
        return;
      end
      s.push_back(8'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    byte_q_t s;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.cpu_done = 1'b0;
    do_reset();

    s = '{8'h02, 8'h00, 8'h34, 8'h01, 8'hFF, 8'h00};
    run_load(s, 1'b0, 50);

    s = '{8'h00, 8'h00};
    run_load(s, 1'b0, 3);

    s = '{8'h01, 8'h00, 8'h12, 8'h02};
    run_load(s, 1'b0, 0);

    s = '{8'h01, 8'h04};
    run_load(s, 1'b0, 0);

    for (int k = 0; k < 8; k++) begin
      rand_stream($urandom_range(1, 8), 1'b1, s);
      run_load(s, 1'b1, $urandom_range(0, 6));
    end

    rand_stream(1 << AW, 1'b0, s);
    run_load(s, 1'b0, 2);

    rand_stream(5, 1'b0, s);
    while (s.size() > 7) s.pop_back();
    run_load(s, 1'b1, 0);

    rand_stream($urandom_range(1, 6), 1'b0, s);
    run_load(s, 1'b1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
